// File: rtl/fft_mag_writer.sv
// rtl/fft_mag_writer.sv - FFT magnitude to 8-bit display buffer frame writer (optional log mode: FFT_MAG_LOG_EN)
module fft_mag_writer #(
    parameter int N_BINS     = 1024,
    parameter int SHIFT      = 9,
    parameter int CONTINUOUS = 0
) (
    input  logic        adc_clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [15:0] s_re,
    input  logic [15:0] s_im,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        frame_req,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        short_frame,
    output logic        fft_buf_wr,
    output logic [9:0]  fft_buf_addr,
    output logic [7:0]  fft_buf_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_CAPTURE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    localparam logic [9:0] LAST_BIN = 10'(N_BINS - 1);

    state_t      r_state;
    logic        r_ready;
    logic [9:0]  r_bin_cnt;
    logic        r_short;
    logic        r_done;

    logic        r_s1_v;
    logic [16:0] r_s1_a;
    logic [16:0] r_s1_b;
    logic [9:0]  r_s1_addr;

    logic        r_s2_v;
    logic [17:0] r_s2_mag;
    logic [9:0]  r_s2_addr;

    logic        r_wr;
    logic [9:0]  r_addr;
    logic [7:0]  r_data;

    logic        w_accept;
    logic        w_load;
    logic [16:0] w_re_ext;
    logic [16:0] w_im_ext;
    logic [16:0] w_abs_re;
    logic [16:0] w_abs_im;
    logic [16:0] w_max;
    logic [16:0] w_min;
    logic [17:0] w_mag;
    logic [7:0]  w_s3_data;

    assign w_accept = s_valid && r_ready;
    assign w_load   = w_accept && (r_state == S_CAPTURE);

    // Sign-extend to 17 bits so that |-32768| = 32768 fits without wrapping
    assign w_re_ext = {s_re[15], s_re};
    assign w_im_ext = {s_im[15], s_im};
    assign w_abs_re = s_re[15] ? (~w_re_ext + 17'd1) : w_re_ext;
    assign w_abs_im = s_im[15] ? (~w_im_ext + 17'd1) : w_im_ext;

    // Alpha-max-plus-beta-min with alpha=1, beta=1/2
    assign w_max = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
    assign w_min = (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
    assign w_mag = {1'b0, w_max} + {2'b00, w_min[16:1]};

`ifdef FFT_MAG_LOG_EN
    logic [4:0] w_lead;
    logic [2:0] w_mant;

    // Position of the most significant set bit of the magnitude
    always_comb begin
        w_lead = 5'd0;
        for (int i = 0; i < 18; i++) begin
            if (r_s2_mag[i]) begin
                w_lead = 5'(i);
            end
        end
    end

    // Shifting the zero-padded magnitude by the lead index lands the three
    // bits below the leading one in [2:0], with zero fill when lead < 3
    assign w_mant    = 3'({r_s2_mag, 3'b000} >> w_lead);
    assign w_s3_data = {w_lead, w_mant};
`else
    logic [17:0] w_shifted;

    assign w_shifted = r_s2_mag >> SHIFT;
    assign w_s3_data = (|w_shifted[17:8]) ? 8'd255 : w_shifted[7:0];
`endif

    // Three-stage magnitude pipeline; valid bits advance every cycle so gaps become write bubbles
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_addr <= '0;
            r_s2_v    <= 1'b0;
            r_s2_mag  <= '0;
            r_s2_addr <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_s1_v <= w_load;
            if (w_load) begin
                r_s1_a    <= w_abs_re;
                r_s1_b    <= w_abs_im;
                r_s1_addr <= r_bin_cnt;
            end
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_mag  <= w_mag;
                r_s2_addr <= r_s1_addr;
            end
            r_wr <= r_s2_v;
            if (r_s2_v) begin
                r_addr <= r_s2_addr;
                r_data <= w_s3_data;
            end
        end
    end

    // Frame capture FSM: arm, align to the FFT frame boundary, count bins, drain pipeline
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_bin_cnt <= '0;
            r_short   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_req || (CONTINUOUS != 0)) begin
                        r_state <= S_SYNC;
                        r_short <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (w_accept && s_last) begin
                        r_state   <= S_CAPTURE;
                        r_bin_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_accept) begin
                        r_bin_cnt <= r_bin_cnt + 10'd1;
                        if (r_bin_cnt == LAST_BIN) begin
                            r_state <= S_FLUSH;
                        end else if (s_last) begin
                            r_state <= S_FLUSH;
                            r_short <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // The final write is on the bus when only stage 3 is still occupied
                    if (!r_s1_v && !r_s2_v && r_wr) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready      = r_ready;
    assign frame_busy   = (r_state != S_IDLE);
    assign frame_done   = r_done;
    assign short_frame  = r_short;
    assign fft_buf_wr   = r_wr;
    assign fft_buf_addr = r_addr;
    assign fft_buf_data = r_data;

endmodule

// File: tb/tb_fft_mag_writer.sv
// tb/tb_fft_mag_writer.sv - scoreboard testbench for fft_mag_writer
module tb_fft_mag_writer;

`ifdef FFT_MAG_LOG_EN
    localparam int E_B5  = 120;
    localparam int E_B6  = 123;
    localparam int E_B7  = 124;
    localparam int E_SAT = 111;
`else
    localparam int E_B5  = 64;
    localparam int E_B6  = 95;
    localparam int E_B7  = 96;
    localparam int E_SAT = 255;
`endif

    logic        clk;
    logic        rst_n;

    logic        s_valid_a, s_last_a, s_ready_a, frame_req_a;
    logic [15:0] s_re_a, s_im_a;
    logic        busy_a, done_a, short_a, wr_a;
    logic [9:0]  addr_a;
    logic [7:0]  data_a;

    logic        s_valid_b, s_last_b, s_ready_b, frame_req_b;
    logic [15:0] s_re_b, s_im_b;
    logic        busy_b, done_b, short_b, wr_b;
    logic [9:0]  addr_b;
    logic [7:0]  data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    logic prev_wr_a = 1'b0;
    logic prev_wr_b = 1'b0;
    logic done_seen_b = 1'b0;
    int low_run_b = 0;

    logic [17:0] q_a[$];
    logic [17:0] q_b[$];

    fft_mag_writer #(.N_BINS(1024), .SHIFT(9), .CONTINUOUS(0)) u_dut_a (
        .adc_clk(clk), .rst_n(rst_n),
        .s_valid(s_valid_a), .s_re(s_re_a), .s_im(s_im_a), .s_last(s_last_a),
        .s_ready(s_ready_a), .frame_req(frame_req_a), .frame_busy(busy_a),
        .frame_done(done_a), .short_frame(short_a), .fft_buf_wr(wr_a),
        .fft_buf_addr(addr_a), .fft_buf_data(data_a)
    );

    fft_mag_writer #(.N_BINS(16), .SHIFT(4), .CONTINUOUS(1)) u_dut_b (
        .adc_clk(clk), .rst_n(rst_n),
        .s_valid(s_valid_b), .s_re(s_re_b), .s_im(s_im_b), .s_last(s_last_b),
        .s_ready(s_ready_b), .frame_req(frame_req_b), .frame_busy(busy_b),
        .frame_done(done_b), .short_frame(short_b), .fft_buf_wr(wr_b),
        .fft_buf_addr(addr_b), .fft_buf_data(data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_mag(input int re, input int im, input int sh);
        int a, b, mag, p, m, v;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        mag = (a > b) ? (a + b / 2) : (b + a / 2);
`ifdef FFT_MAG_LOG_EN
        if (mag == 0) return 0;
        p = 0;
        for (int t = mag; t > 1; t = t / 2) p++;
        m = ((mag * 8) >> p) % 8;
        v = sh;
        return p * 8 + m + (v - sh);
`else
        p = 0;
        m = 0;
        v = mag >> sh;
        return (v > 255) ? 255 + p + m : v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input int re, input int im, input logic last,
                          input logic push, input int addr, input int exp);
        s_valid_a = 1'b1;
        s_re_a    = 16'(re);
        s_im_a    = 16'(im);
        s_last_a  = last;
        if (push) q_a.push_back({10'(addr), 8'(exp)});
        tick();
    endtask

    task automatic beat_b(input int re, input int im, input logic last,
                          input logic push, input int addr, input int exp);
        s_valid_b = 1'b1;
        s_re_b    = 16'(re);
        s_im_b    = 16'(im);
        s_last_b  = last;
        if (push) q_b.push_back({10'(addr), 8'(exp)});
        tick();
    endtask

    // Monitor for instance A: pop expected write, check frame_done follows the final write
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_wr_addr", int'(addr_a), -1);
                end else begin
                    logic [17:0] e;
                    e = q_a.pop_front();
                    check("a_wr_addr_data", int'({addr_a, data_a}), int'(e));
                end
            end
            if (done_a) begin
                done_cnt_a++;
                check("a_done_after_last_wr", int'(prev_wr_a), 1);
                check("a_done_queue_left", q_a.size(), 0);
            end
            prev_wr_a = wr_a;
        end else begin
            prev_wr_a = 1'b0;
        end
    end

    // Monitor for instance B: writes, done pulses and the one-cycle busy gap between frames
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_wr_addr", int'(addr_b), -1);
                end else begin
                    logic [17:0] e;
                    e = q_b.pop_front();
                    check("b_wr_addr_data", int'({addr_b, data_b}), int'(e));
                end
            end
            if (done_b) begin
                done_cnt_b++;
                done_seen_b = 1'b1;
                check("b_done_after_last_wr", int'(prev_wr_b), 1);
            end
            if (!busy_b) begin
                low_run_b++;
            end else begin
                if (done_seen_b && low_run_b != 0) check("b_busy_gap", low_run_b, 1);
                low_run_b = 0;
            end
            prev_wr_b = wr_b;
        end else begin
            prev_wr_b = 1'b0;
            low_run_b = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_valid_a = 0; s_re_a = 0; s_im_a = 0; s_last_a = 0; frame_req_a = 0;
        s_valid_b = 0; s_re_b = 0; s_im_b = 0; s_last_b = 0; frame_req_b = 0;
        repeat (3) tick();
        check("rst_s_ready_a", int'(s_ready_a), 0);
        check("rst_s_ready_b", int'(s_ready_b), 0);
        check("rst_wr_a", int'(wr_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_done_a", int'(done_a), 0);
        check("rst_short_a", int'(short_a), 0);
        check("rst_addr_data_a", int'({addr_a, data_a}), 0);
        rst_n = 1'b1;
        tick();
        check("s_ready_after_rst", int'(s_ready_a), 1);
        check("idle_busy_a", int'(busy_a), 0);

        // Full frame: garbage, sync s_last, 1024 bins with s_last on the final bin
        frame_req_a = 1'b1;
        tick();
        check("busy_after_req", int'(busy_a), 1);
        frame_req_a = 1'b0;
        for (int i = 0; i < 5; i++) beat_a(1234 + i, -77, 1'b0, 1'b0, 0, 0);
        beat_a(5, 5, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 1024; i++) begin
            if (i == 5)      beat_a(-32768, 0, 1'b0, 1'b1, i, E_B5);
            else if (i == 6) beat_a(32767, 32767, 1'b0, 1'b1, i, E_B6);
            else if (i == 7) beat_a(-32768, -32768, 1'b0, 1'b1, i, E_B7);
            else             beat_a(0, 0, (i == 1023), 1'b1, i, 0);
        end
        s_valid_a = 1'b0;
        for (int k = 0; k < 50 && done_cnt_a < 1; k++) tick();
        check("a_done_count_full", done_cnt_a, 1);
        check("a_short_full", int'(short_a), 0);
        check("a_busy_after_full", int'(busy_a), 0);

        // Idle: beats must not be written without frame_req
        for (int i = 0; i < 4; i++) beat_a(1000, 1000, (i == 2), 1'b0, 0, 0);
        s_valid_a = 1'b0;

        // Short frame: s_last on beat 500 with valid gaps
        frame_req_a = 1'b1;
        tick();
        frame_req_a = 1'b0;
        beat_a(0, 0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            beat_a(i * 64, -(i * 3), (i == 499), 1'b1, i, exp_mag(i * 64, -(i * 3), 9));
            if (i % 7 == 3) begin
                s_valid_a = 1'b0;
                tick();
            end
        end
        s_valid_a = 1'b0;
        for (int k = 0; k < 50 && done_cnt_a < 2; k++) tick();
        check("a_done_count_short", done_cnt_a, 2);
        check("a_short_set", int'(short_a), 1);
        repeat (3) tick();
        check("a_done_once_short", done_cnt_a, 2);

        // Next capture start clears short_frame; reset during capture at bin 300
        frame_req_a = 1'b1;
        tick();
        frame_req_a = 1'b0;
        check("a_short_cleared", int'(short_a), 0);
        beat_a(0, 0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 300; i++) beat_a(0, 0, 1'b0, 1'b1, i, 0);
        s_valid_a = 1'b1;
        #2;
        check("a_wr_before_rst", int'(wr_a), 1);
        rst_n = 1'b0;
        #1;
        check("a_wr_rst_same_cycle", int'(wr_a), 0);
        q_a.delete();
        s_valid_a = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("a_busy_after_rst", int'(busy_a), 0);
        for (int i = 0; i < 40; i++) beat_a(500, 500, (i % 10 == 9), 1'b0, 0, 0);
        s_valid_a = 1'b0;
        repeat (5) tick();
        check("a_no_done_after_rst", done_cnt_a, 2);

        // Continuous instance: odd stream frames are captured, even ones consumed by SYNC
        for (int f = 0; f < 9; f++) begin
            for (int i = 0; i < 16; i++) begin
                int re, im, e;
                if (f == 1 && i == 0) begin
                    re = 16000; im = 0; e = E_SAT;
                end else if (f == 1 && i == 1) begin
                    re = 1; im = 0; e = 0;
                end else begin
                    re = int'($signed(16'($urandom)));
                    im = int'($signed(16'($urandom)));
                    e = exp_mag(re, im, 4);
                end
                beat_b(re, im, (i == 15), (f % 2 == 1), i, e);
                if ($urandom_range(0, 1) == 1) begin
                    s_valid_b = 1'b0;
                    tick();
                end
            end
        end
        s_valid_b = 1'b0;
        for (int k = 0; k < 50 && done_cnt_b < 4; k++) tick();
        check("b_done_count", done_cnt_b, 4);
        check("b_queue_empty", q_b.size(), 0);
        check("b_short", int'(short_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
